cpu_sequencer: RTL

//  Control-unit FSM that drives the accumulator ALU's control inputs and sequences fetch/decode/execute.

---
 rtl/cpu_sequencer.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Control-unit FSM for a small accumulator CPU. It sequences
//   fetch / decode / execute. It drives the PC, IR, MAR, memory strobes and
//   ALU controls. It stalls on the memory ready handshake and raises a sticky
//   bus_error when a memory access hangs.
//
//   Optional feature macro: CPU_SEQ_HALT_EN
//     When defined, opcode 111 parks the sequencer in HALT (halted=1) until
//     reset. When undefined, opcode 111 is a NOP and halted is tied low.
//
// Ports
//   clock, reset             system clock; synchronous active-high reset
//   opcode [OP_W-1:0]        IR opcode field, valid in DECODE/EXEC
//   z_flag                   ALU accumulator-zero flag (used by BZ)
//   mem_ready                memory access complete this cycle
//   PC_bus/load_PC/INC_PC    program counter controls
//   Addr_bus/load_MAR/load_IR  operand drive, MAR load, IR load
//   mem_read/mem_write       memory strobes, held until mem_ready
//   ACC_bus/load_ACC/ALU_ACC accumulator controls
//   ALU_add/ALU_sub/ALU_xor  ALU operation select (one-hot or all 0)
//   bus_error                sticky memory-timeout flag
//   halted                   sequencer parked in HALT
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int OP_W     = 3,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 12
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            load_IR,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            ALU_xor,
    output logic            bus_error,
    output logic            halted
);

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(3'd0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(3'd1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3'd2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3'd3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(3'd4);
    localparam logic [OP_W-1:0] OP_BZ    = OP_W'(3'd5);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(3'd6);
    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(3'd7);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(0);

    typedef enum logic [2:0] {
        ST_FETCH_ADDR = 3'd0,
        ST_FETCH_DATA = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXEC       = 3'd3,
`ifdef CPU_SEQ_HALT_EN
        ST_FAULT      = 3'd4,
        ST_HALT       = 3'd5
`else
        ST_FAULT      = 3'd4
`endif
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              bus_error_r;
    logic              in_wait_s;
    logic              timeout_s;
    logic              mem_op_s;

    // Raw (ungated) decoded controls; reset gating is applied on the ports.
    logic pc_bus_s, load_pc_s, inc_pc_s, addr_bus_s, load_mar_s, load_ir_s;
    logic mem_read_s, mem_write_s, acc_bus_s, load_acc_s, alu_acc_s;
    logic alu_add_s, alu_sub_s, alu_xor_s, halted_s;

    // Memory-operand opcodes go through EXEC; the rest finish in DECODE.
    assign mem_op_s = (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                      (opcode == OP_ADD)  || (opcode == OP_SUB)   ||
                      (opcode == OP_XOR);

    // A wait cycle is any memory-access cycle in which memory has not answered.
    assign in_wait_s = ((state_r == ST_FETCH_DATA) || (state_r == ST_EXEC)) && !mem_ready;
    // The counter has already seen MAX_WAIT stalled cycles; one more is a hang.
    assign timeout_s = in_wait_s && (wait_cnt_r == WAIT_LIMIT);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_FETCH_ADDR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Wait-state counter: counts stalled cycles, restarts on every state change.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_r <= WAIT_ZERO;
        end else if (next_state_s != state_r) begin
            wait_cnt_r <= WAIT_ZERO;
        end else if (in_wait_s && (wait_cnt_r != WAIT_SAT)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky memory-timeout flag; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_error_r <= 1'b0;
        end else if (timeout_s) begin
            bus_error_r <= 1'b1;
        end else begin
            bus_error_r <= bus_error_r;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH_ADDR: next_state_s = ST_FETCH_DATA;
            ST_FETCH_DATA: begin
                if (mem_ready) begin
                    next_state_s = ST_DECODE;
                end else if (timeout_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_FETCH_DATA;
                end
            end
            ST_DECODE: begin
                if (mem_op_s) begin
                    next_state_s = ST_EXEC;
`ifdef CPU_SEQ_HALT_EN
                end else if (opcode == OP_NOP) begin
                    next_state_s = ST_HALT;
`endif
                end else begin
                    next_state_s = ST_FETCH_ADDR;
                end
            end
            ST_EXEC: begin
                if (mem_ready) begin
                    next_state_s = ST_FETCH_ADDR;
                end else if (timeout_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_FAULT: next_state_s = ST_FAULT;
`ifdef CPU_SEQ_HALT_EN
            ST_HALT:  next_state_s = ST_HALT;
`endif
            default:  next_state_s = ST_FETCH_ADDR;
        endcase
    end

    // Output decode (Mealy on mem_ready, opcode and z_flag where needed).
    always_comb begin
        pc_bus_s    = 1'b0;
        load_pc_s   = 1'b0;
        inc_pc_s    = 1'b0;
        addr_bus_s  = 1'b0;
        load_mar_s  = 1'b0;
        load_ir_s   = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        acc_bus_s   = 1'b0;
        load_acc_s  = 1'b0;
        alu_acc_s   = 1'b0;
        alu_add_s   = 1'b0;
        alu_sub_s   = 1'b0;
        alu_xor_s   = 1'b0;
        halted_s    = 1'b0;
        case (state_r)
            ST_FETCH_ADDR: begin
                pc_bus_s   = 1'b1;
                load_mar_s = 1'b1;
            end
            ST_FETCH_DATA: begin
                mem_read_s = 1'b1;
                load_ir_s  = mem_ready;
                inc_pc_s   = mem_ready;
            end
            ST_DECODE: begin
                addr_bus_s = 1'b1;
                if (mem_op_s) begin
                    load_mar_s = 1'b1;
                end else if (opcode == OP_JMP) begin
                    load_pc_s = 1'b1;
                end else if (opcode == OP_BZ) begin
                    load_pc_s = z_flag;
                end else begin
                    load_pc_s = 1'b0;
                end
            end
            ST_EXEC: begin
                if (opcode == OP_STORE) begin
                    acc_bus_s   = 1'b1;
                    mem_write_s = 1'b1;
                end else begin
                    mem_read_s = 1'b1;
                    load_acc_s = mem_ready;
                    // LOAD writes memory data straight into ACC; the rest go through the ALU.
                    alu_acc_s  = mem_ready && (opcode != OP_LOAD);
                    alu_add_s  = mem_ready && (opcode == OP_ADD);
                    alu_sub_s  = mem_ready && (opcode == OP_SUB);
                    alu_xor_s  = mem_ready && (opcode == OP_XOR);
                end
            end
            ST_FAULT: halted_s = 1'b0;
`ifdef CPU_SEQ_HALT_EN
            ST_HALT:  halted_s = 1'b1;
`endif
            default:  halted_s = 1'b0;
        endcase
    end

    // Reset gates every control combinationally so strobes drop in the same cycle.
    assign PC_bus    = pc_bus_s    & ~reset;
    assign load_PC   = load_pc_s   & ~reset;
    assign INC_PC    = inc_pc_s    & ~reset;
    assign Addr_bus  = addr_bus_s  & ~reset;
    assign load_MAR  = load_mar_s  & ~reset;
    assign load_IR   = load_ir_s   & ~reset;
    assign mem_read  = mem_read_s  & ~reset;
    assign mem_write = mem_write_s & ~reset;
    assign ACC_bus   = acc_bus_s   & ~reset;
    assign load_ACC  = load_acc_s  & ~reset;
    assign ALU_ACC   = alu_acc_s   & ~reset;
    assign ALU_add   = alu_add_s   & ~reset;
    assign ALU_sub   = alu_sub_s   & ~reset;
    assign ALU_xor   = alu_xor_s   & ~reset;
    assign bus_error = bus_error_r & ~reset;
    assign halted    = halted_s    & ~reset;

endmodule
